// File: rtl/axis_write_data.sv
// rtl/axis_write_data.sv - packs a DATA_WIDTH stream into AXI write-data beats
// through a first-word-fall-through buffer, with burst-aligned wlast.
module axis_write_data #(
  parameter int BUF_AWIDTH     = 4,
  parameter int CFG_DWIDTH     = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int CONVERT_SHIFT  = 1,
  parameter int AXI_LEN_WIDTH  = 4,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  output logic                      axi_wlast,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic                      valid,
  output logic                      ready
);

  localparam int DEPTH  = 1 << BUF_AWIDTH;
  localparam int LANE_W = (CONVERT_SHIFT > 0) ? CONVERT_SHIFT : 1;
  localparam logic [CFG_DWIDTH-1:0]    REM_MASK  = CFG_DWIDTH'(WIDTH_RATIO - 1);
  localparam logic [AXI_LEN_WIDTH-1:0] BURST_END = '1;

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;

  logic [CFG_DWIDTH-1:0]     words_left;
  logic [CFG_DWIDTH-1:0]     beats_total;
  logic [CFG_DWIDTH-1:0]     beat_idx;
  logic [CFG_DWIDTH-1:0]     beats_calc;
  logic [LANE_W-1:0]         lane;
  logic [AXI_DATA_WIDTH-1:0] pack_q;
  logic [AXI_DATA_WIDTH-1:0] pack_next;
  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [BUF_AWIDTH-1:0]     wr_ptr;
  logic [BUF_AWIDTH-1:0]     rd_ptr;
  logic [BUF_AWIDTH:0]       count;

  logic fifo_full;
  logic group_done;
  logic word_take;
  logic push;
  logic pop;
  logic beats_round_up;

  assign beats_round_up = |(cfg_length & REM_MASK);
  assign beats_calc     = (cfg_length >> CONVERT_SHIFT) + CFG_DWIDTH'(beats_round_up);

  assign fifo_full  = (count == (BUF_AWIDTH + 1)'(DEPTH));
  assign group_done = (int'(lane) == WIDTH_RATIO - 1) || (words_left == CFG_DWIDTH'(1));

  assign axi_wvalid = !rst && (count != '0);
  assign axi_wdata  = axi_wvalid ? mem[rd_ptr] : '0;
  assign axi_wlast  = axi_wvalid &&
                      ((beat_idx[AXI_LEN_WIDTH-1:0] == BURST_END) ||
                       (beat_idx == beats_total - CFG_DWIDTH'(1)));
  assign pop        = axi_wvalid && axi_wready;

  // A full buffer still admits the group-completing word when a beat drains that cycle.
  assign ready     = !rst && (state == ACTIVE) && (words_left != '0) &&
                     (!fifo_full || (group_done && pop));
  assign word_take = valid && ready;
  assign push      = word_take && group_done;
  assign cfg_rdy   = !rst && (state == IDLE);

  always_comb begin
    pack_next = pack_q;
    for (int k = 0; k < WIDTH_RATIO; k++) begin
      if (int'(lane) == k) pack_next[k*DATA_WIDTH +: DATA_WIDTH] = data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pack_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      words_left  <= '0;
      beats_total <= '0;
      beat_idx    <= '0;
      lane        <= '0;
      pack_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_val && (cfg_length != '0)) begin
            state       <= ACTIVE;
            words_left  <= cfg_length;
            beats_total <= beats_calc;
            beat_idx    <= '0;
            lane        <= '0;
            pack_q      <= '0;
          end
        end
        ACTIVE: begin
          if (word_take) begin
            words_left <= words_left - CFG_DWIDTH'(1);
            // Clearing the packer on completion keeps unused lanes of a short final group zero.
            if (group_done) begin
              lane   <= '0;
              pack_q <= '0;
            end else begin
              lane   <= lane + LANE_W'(1);
              pack_q <= pack_next;
            end
          end
          if (pop) begin
            beat_idx <= beat_idx + CFG_DWIDTH'(1);
            if (beat_idx == beats_total - CFG_DWIDTH'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + BUF_AWIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + BUF_AWIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (BUF_AWIDTH + 1)'(1);
        2'b01:   count <= count - (BUF_AWIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_write_data.sv
// tb/tb_axis_write_data.sv - vector-table, hand-sequence and randomized checks for axis_write_data
module tb_axis_write_data;
  localparam int R     = 2;
  localparam int DW    = 32;
  localparam int BURST = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_length;
  logic        cfg_val;
  logic        cfg_rdy;
  logic [63:0] axi_wdata;
  logic        axi_wvalid;
  logic        axi_wready;
  logic        axi_wlast;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  int n_vec = 0;
  int n_bad = 0;

  axis_write_data dut (
    .clk(clk), .rst(rst),
    .cfg_length(cfg_length), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .data(data), .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          gap;
    int          pct;
    int          hold;
    int          exp_lasts;
    int          exp_hold_acc;
    logic [63:0] exp_last_beat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one transfer and scores every beat against beats built directly from the word list.
  task automatic run_xfer(input int len, input int gap, input int pct, input int hold, input bit rnd,
                          output int n_last, output logic [63:0] last_beat, output int acc_hold);
    logic [31:0] words[$];
    logic [63:0] exp[$];
    logic [63:0] w, prev_data;
    int nb, wi, bi, gapc, cyc, budget;
    bit prev_hold, prev_complete, took;

    words.delete();
    exp.delete();
    for (int i = 0; i < len; i++) words.push_back(rnd ? 32'($urandom) : 32'(i + 1));
    nb = (len + R - 1) / R;
    for (int b = 0; b < nb; b++) begin
      w = '0;
      for (int k = 0; k < R; k++)
        if (b * R + k < len) w[k*DW +: DW] = words[b*R + k];
      exp.push_back(w);
    end

    @(negedge clk);
    cfg_length = 32'(len);
    cfg_val    = 1'b1;
    valid      = 1'b0;
    axi_wready = 1'b0;
    #1;
    chk("cfg_rdy_before_cfg", {63'd0, cfg_rdy}, 64'd1);
    @(negedge clk);

    wi = 0; bi = 0; gapc = gap; cyc = 0; n_last = 0; last_beat = '0; acc_hold = -1;
    prev_hold = 0; prev_complete = 0; prev_data = '0;
    budget = 30 * len + 2000 + hold;
    while (bi < nb && cyc < budget) begin
      if (cyc == hold) acc_hold = wi;
      cfg_val    = 1'($urandom_range(1));
      cfg_length = $urandom;
      if (wi < len) valid = (gapc >= gap);
      else          valid = 1'($urandom_range(1));
      data       = (wi < len && valid) ? words[wi] : $urandom;
      axi_wready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pct);
      #1;
      chk("cfg_rdy_active", {63'd0, cfg_rdy}, 64'd0);
      if (!axi_wvalid) chk("wlast_without_wvalid", {63'd0, axi_wlast}, 64'd0);
      if (prev_hold) begin
        chk("wvalid_held", {63'd0, axi_wvalid}, 64'd1);
        chk("wdata_held", axi_wdata, prev_data);
      end
      if (prev_complete) chk("beat_latency", {63'd0, axi_wvalid}, 64'd1);
      if (wi >= len) chk("ready_after_len", {63'd0, ready}, 64'd0);

      took = valid && ready && (wi < len);
      prev_complete = took && ((wi % R == R - 1) || (wi == len - 1));
      if (took) begin
        wi++;
        gapc = 0;
      end else begin
        gapc++;
      end

      if (axi_wvalid && axi_wready) begin
        chk($sformatf("beat%0d_data", bi), axi_wdata, exp[bi]);
        chk($sformatf("beat%0d_wlast", bi), {63'd0, axi_wlast},
            {63'd0, ((bi % BURST) == BURST - 1) || (bi == nb - 1)});
        if (axi_wlast) n_last++;
        last_beat = axi_wdata;
        bi++;
      end
      prev_hold = axi_wvalid && !axi_wready;
      prev_data = axi_wdata;
      cyc++;
      @(negedge clk);
    end
    if (bi < nb) chk("xfer_timeout_beats", 64'(bi), 64'(nb));

    cfg_val    = 1'b0;
    valid      = 1'b1;
    axi_wready = 1'b0;
    #1;
    chk("cfg_rdy_after_xfer", {63'd0, cfg_rdy}, 64'd1);
    chk("wvalid_after_xfer", {63'd0, axi_wvalid}, 64'd0);
    chk("ready_in_idle", {63'd0, ready}, 64'd0);
    valid = 1'b0;
  endtask

  initial begin
    int          n_last, acc_hold, rlen, nbr;
    logic [63:0] last_beat;

    tbl[0] = '{8,    0, 100, 0,  1, -1, 64'h0000000800000007};
    tbl[1] = '{8,    1, 50,  12, 1, -1, 64'h0000000800000007};
    tbl[2] = '{8,    5, 100, 0,  1, -1, 64'h0000000800000007};
    tbl[3] = '{4092, 0, 100, 0,  128, -1, 64'h00000FFC00000FFB};
    tbl[4] = '{40,   0, 100, 40, 2, 32, 64'h0000002800000027};
    tbl[5] = '{3,    0, 100, 0,  1, -1, 64'h0000000000000003};
    tbl[6] = '{1,    0, 100, 0,  1, -1, 64'h0000000000000001};
    tbl[7] = '{33,   2, 70,  5,  2, -1, 64'h0000000000000021};
    tbl[8] = '{32,   0, 100, 0,  1, -1, 64'h000000200000001F};

    rst = 1'b1; cfg_val = 1'b0; cfg_length = '0; valid = 1'b0; data = '0; axi_wready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cfg_rdy", {63'd0, cfg_rdy}, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_wvalid", {63'd0, axi_wvalid}, 64'd0);
    chk("rst_wlast", {63'd0, axi_wlast}, 64'd0);
    chk("rst_wdata", axi_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("cfg_rdy_after_rst", {63'd0, cfg_rdy}, 64'd1);

    // Zero length must be ignored.
    @(negedge clk);
    cfg_val = 1'b1; cfg_length = '0; valid = 1'b1;
    @(negedge clk);
    cfg_val = 1'b0;
    #1;
    chk("zero_len_cfg_rdy", {63'd0, cfg_rdy}, 64'd1);
    chk("zero_len_ready", {63'd0, ready}, 64'd0);
    valid = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_xfer(tbl[v].len, tbl[v].gap, tbl[v].pct, tbl[v].hold, 1'b0, n_last, last_beat, acc_hold);
      chk($sformatf("vec%0d_wlast_count", v), 64'(n_last), 64'(tbl[v].exp_lasts));
      chk($sformatf("vec%0d_last_beat", v), last_beat, tbl[v].exp_last_beat);
      if (tbl[v].exp_hold_acc >= 0)
        chk($sformatf("vec%0d_words_before_full", v), 64'(acc_hold), 64'(tbl[v].exp_hold_acc));
    end

    // Reset in the middle of a transfer with a partial group and a buffered beat.
    @(negedge clk);
    cfg_val = 1'b1; cfg_length = 32'd8;
    @(negedge clk);
    cfg_val = 1'b0; axi_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; data = 32'(100 + i);
      #1;
      chk("mid_ready", {63'd0, ready}, 64'd1);
      @(negedge clk);
    end
    valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    valid = 1'b1;
    #1;
    chk("mid_rst_wvalid", {63'd0, axi_wvalid}, 64'd0);
    chk("mid_rst_ready", {63'd0, ready}, 64'd0);
    chk("mid_rst_cfg_rdy", {63'd0, cfg_rdy}, 64'd0);
    chk("mid_rst_wdata", axi_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_cfg_rdy_after", {63'd0, cfg_rdy}, 64'd1);
    chk("mid_rst_wvalid_after", {63'd0, axi_wvalid}, 64'd0);
    run_xfer(8, 0, 100, 0, 1'b0, n_last, last_beat, acc_hold);
    chk("post_rst_wlast_count", 64'(n_last), 64'd1);
    chk("post_rst_last_beat", last_beat, 64'h0000000800000007);

    for (int t = 0; t < 25; t++) begin
      rlen = $urandom_range(50, 1);
      nbr  = (rlen + R - 1) / R;
      run_xfer(rlen, $urandom_range(3), $urandom_range(100, 30), $urandom_range(40),
               1'b1, n_last, last_beat, acc_hold);
      chk($sformatf("rand%0d_wlast_count", t), 64'(n_last), 64'((nbr + BURST - 1) / BURST));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
